// File: rtl/mem_access_pkg.sv
// Shared types and lane helpers for the data-memory access controller.
// Size codes follow the request encoding; code 3 is reserved and always rejected.
package mem_access_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_STROBE,
        ST_RD_WAIT,
        ST_WR_STROBE,
        ST_RESP
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    // Pull the addressed byte/halfword out of a word and extend it.
    function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] off, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {off, 3'b000});
        h = 16'(word >> {off[1], 4'b0000});
        case (size)
            SZ_BYTE: return {{24{sgn & b[7]}}, b};
            SZ_HALF: return {{16{sgn & h[15]}}, h};
            default: return word;
        endcase
    endfunction

    // Replace the addressed lane of a word with right-aligned store data.
    function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [31:0] wdata,
                                               input logic [1:0] size, input logic [1:0] off);
        logic [31:0] mask;
        logic [31:0] ins;
        case (size)
            SZ_BYTE: begin
                mask = 32'h0000_00FF << {off, 3'b000};
                ins  = {24'h0, wdata[7:0]} << {off, 3'b000};
            end
            SZ_HALF: begin
                mask = 32'h0000_FFFF << {off[1], 4'b0000};
                ins  = {16'h0, wdata[15:0]} << {off[1], 4'b0000};
            end
            default: begin
                mask = '1;
                ins  = wdata;
            end
        endcase
        return (word & ~mask) | ins;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: load extraction/extension and sub-word store merge.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    assign load_data = lane_extract(rdata, size, offset, sgn);
    assign merged    = lane_merge(rdata, wdata, size, offset);

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store initiator for a word-organised data memory without byte enables.
// Build option MEM_ACCESS_CTRL_MISALIGN_TRAP_EN traps misaligned accesses instead of aligning them.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int READ_LAT  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [1:0]  reqSize,
    input  logic        reqSigned,
    input  logic [31:0] reqAddr,
    input  logic [31:0] reqWdata,
    output logic        respValid,
    output logic [31:0] respRdata,
    output logic        respErr,
    output logic [31:0] memAddress,
    output logic [31:0] memWriteData,
    output logic        memRead,
    output logic        memWrite,
    input  logic [31:0] memReadData
);

    localparam logic [2:0] LAST_WAIT = 3'(READ_LAT - 1);

    state_t      state;
    req_t        req_q;
    logic [2:0]  wait_cnt;
    logic [31:0] wr_word;
    logic [31:0] addr_aln;
    logic        misalign_err;
    logic        illegal;
    logic        last_wait;
    logic [31:0] load_data;
    logic [31:0] merged;

    always_comb begin
        addr_aln = reqAddr;
        case (reqSize)
            SZ_HALF: addr_aln[0]   = 1'b0;
            SZ_WORD: addr_aln[1:0] = 2'b00;
            default: ;
        endcase
    end

`ifdef MEM_ACCESS_CTRL_MISALIGN_TRAP_EN
    assign misalign_err = (reqSize == SZ_HALF && reqAddr[0]) ||
                          (reqSize == SZ_WORD && reqAddr[1:0] != 2'b00);
`else
    assign misalign_err = 1'b0;
`endif

    assign illegal   = (reqSize == 2'd3) || ({2'b00, addr_aln[31:2]} >= 32'(MEM_WORDS)) || misalign_err;
    assign reqReady  = (state == ST_IDLE);
    assign last_wait = (state == ST_RD_WAIT) && (wait_cnt == LAST_WAIT);

    // Address and write data look ahead one cycle so they are already settled
    // in the cycle before each strobe rises.
    assign memAddress = (state == ST_IDLE && reqValid) ? {2'b00, addr_aln[31:2]}
                                                       : {2'b00, req_q.addr[31:2]};
    always_comb begin
        memWriteData = wr_word;
        if (state == ST_IDLE && reqValid) memWriteData = reqWdata;
        else if (last_wait)               memWriteData = merged;
    end

    mem_lane_align u_align (
        .size      (req_q.size),
        .sgn       (req_q.sgn),
        .offset    (req_q.addr[1:0]),
        .rdata     (memReadData),
        .wdata     (req_q.wdata),
        .load_data (load_data),
        .merged    (merged)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            req_q     <= '0;
            wait_cnt  <= '0;
            wr_word   <= '0;
            memRead   <= 1'b0;
            memWrite  <= 1'b0;
            respValid <= 1'b0;
            respErr   <= 1'b0;
            respRdata <= '0;
        end else begin
            memRead   <= 1'b0;
            memWrite  <= 1'b0;
            respValid <= 1'b0;
            respErr   <= 1'b0;
            respRdata <= '0;
            case (state)
                ST_IDLE: if (reqValid) begin
                    req_q <= '{write: reqWrite, size: reqSize, sgn: reqSigned,
                               addr: addr_aln, wdata: reqWdata};
                    wr_word <= reqWdata;
                    if (illegal) begin
                        state     <= ST_RESP;
                        respValid <= 1'b1;
                        respErr   <= 1'b1;
                    end else if (reqWrite && reqSize == SZ_WORD) begin
                        state    <= ST_WR_STROBE;
                        memWrite <= 1'b1;
                    end else begin
                        state   <= ST_RD_STROBE;
                        memRead <= 1'b1;
                    end
                end
                ST_RD_STROBE: begin
                    state    <= ST_RD_WAIT;
                    wait_cnt <= '0;
                end
                ST_RD_WAIT: begin
                    if (wait_cnt == LAST_WAIT) begin
                        if (req_q.write) begin
                            state    <= ST_WR_STROBE;
                            memWrite <= 1'b1;
                            wr_word  <= merged;
                        end else begin
                            state     <= ST_RESP;
                            respValid <= 1'b1;
                            respRdata <= load_data;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                ST_WR_STROBE: begin
                    state     <= ST_RESP;
                    respValid <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: vector table, scoreboard and strobe monitor.
module tb_mem_access_ctrl;
    import mem_access_pkg::*;

    localparam int RL    = 1;
    localparam int WORDS = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reqValid, reqReady, reqWrite, reqSigned;
    logic [1:0]  reqSize;
    logic [31:0] reqAddr, reqWdata;
    logic        respValid, respErr, memRead, memWrite;
    logic [31:0] respRdata, memAddress, memWriteData, memReadData;

    always #5 clk = ~clk;

    mem_access_ctrl #(.MEM_WORDS(WORDS), .READ_LAT(RL)) dut (
        .clk(clk), .rst(rst), .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
        .reqSize(reqSize), .reqSigned(reqSigned), .reqAddr(reqAddr), .reqWdata(reqWdata),
        .respValid(respValid), .respRdata(respRdata), .respErr(respErr),
        .memAddress(memAddress), .memWriteData(memWriteData), .memRead(memRead),
        .memWrite(memWrite), .memReadData(memReadData)
    );

    typedef struct { logic wr; logic [1:0] sz; logic sg; logic [31:0] addr; logic [31:0] wd;
                     logic err; logic [31:0] rd; } vec_t;
    typedef struct { logic err; logic [31:0] rd; int due; } exp_t;

    int   total = 0, passed = 0, cyc = 0;
    int   rd_cnt = 0, wr_cnt = 0, resp_cnt = 0, last_wr_cyc = 0;
    logic [31:0] last_wr_addr = '0;
    exp_t sb[$];
    vec_t vecs[$];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endfunction

    function automatic vec_t mk(input logic wr, input logic [1:0] sz, input logic sg, input logic [31:0] addr,
                                input logic [31:0] wd, input logic err, input logic [31:0] rd);
        vec_t v;
        v.wr = wr; v.sz = sz; v.sg = sg; v.addr = addr; v.wd = wd; v.err = err; v.rd = rd;
        return v;
    endfunction

    function automatic int exp_lat(input vec_t v);
        if (v.err) return 1;
        if (!v.wr) return 2 + RL;
        if (v.sz == SZ_WORD) return 2;
        return 3 + RL;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Word memory with RL = 1: data appears the cycle after the read strobe, garbage otherwise.
    logic [31:0] mem [WORDS];
    bit loaded = 1'b0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= '0;
            mem[8] <= 32'h0000_80F0;
            loaded <= 1'b1;
        end
        if (memWrite) mem[memAddress[9:0]] <= memWriteData;
        memReadData <= memRead ? mem[memAddress[9:0]] : 32'hBAD0_BAD0;
    end

    // Strobe-protocol monitor and scoreboard consumer.
    logic        prev_rd = 1'b0, prev_wr = 1'b0;
    logic [31:0] prev_addr = '0, prev_wd = '0;
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst) begin
            if (memRead || memWrite) begin
                check("strobe_exclusive", 32'(memRead & memWrite), 32'd0);
                check("strobe_rising", 32'(prev_rd | prev_wr), 32'd0);
                check("addr_setup", memAddress, prev_addr);
                check("addr_range", 32'(memAddress < WORDS), 32'd1);
                check("ready_busy", 32'(reqReady), 32'd0);
                check("rdata_idle", respRdata, 32'd0);
            end
            if (memWrite) begin
                check("wdata_setup", memWriteData, prev_wd);
                wr_cnt       <= wr_cnt + 1;
                last_wr_cyc  <= cyc;
                last_wr_addr <= memAddress;
            end
            if (memRead) rd_cnt <= rd_cnt + 1;
            if (respValid) begin
                resp_cnt <= resp_cnt + 1;
                check("ready_in_resp", 32'(reqReady), 32'd0);
                if (sb.size() == 0) begin
                    check("resp_unexpected", 32'(respValid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("resp_err", 32'(respErr), 32'(e.err));
                    check("resp_rdata", respRdata, e.rd);
                    check("resp_cycle", 32'(cyc), 32'(e.due));
                end
            end
        end
        prev_rd   <= memRead;
        prev_wr   <= memWrite;
        prev_addr <= memAddress;
        prev_wd   <= memWriteData;
    end

    // Drive a request and return at the negedge just before its accept edge.
    task automatic issue(input vec_t v, input bit push, output int acc_cyc);
        bit   ok;
        exp_t e;
        @(posedge clk); #1;
        reqValid = 1'b1; reqWrite = v.wr; reqSize = v.sz; reqSigned = v.sg;
        reqAddr = v.addr; reqWdata = v.wd;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (reqReady) begin ok = 1'b1; break; end
        end
        check("accept_timeout", 32'(ok), 32'd1);
        acc_cyc = cyc;
        if (ok && push) begin
            e.err = v.err; e.rd = v.rd; e.due = cyc + exp_lat(v);
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        bit done;
        @(posedge clk); #1;
        reqValid = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (sb.size() == 0) begin done = 1'b1; break; end
        end
        check("drain_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        int c, rd0, wr0, exp_rd, exp_wr, rc0;
        reqValid = 1'b0; reqWrite = 1'b0; reqSize = SZ_WORD; reqSigned = 1'b0;
        reqAddr = '0; reqWdata = '0;

        vecs.push_back(mk(1, SZ_BYTE, 0, 32'h11,  32'hFFFF_FFA5, 0, 32'h0));
        vecs.push_back(mk(0, SZ_WORD, 0, 32'h10,  32'h0,         0, 32'hDEAD_A5EF));
        vecs.push_back(mk(0, SZ_BYTE, 1, 32'h20,  32'h0,         0, 32'hFFFF_FFF0));
        vecs.push_back(mk(0, SZ_BYTE, 0, 32'h20,  32'h0,         0, 32'h0000_00F0));
        vecs.push_back(mk(0, SZ_HALF, 1, 32'h20,  32'h0,         0, 32'hFFFF_80F0));
        vecs.push_back(mk(0, SZ_HALF, 0, 32'h22,  32'h0,         0, 32'h0000_0000));
        vecs.push_back(mk(1, SZ_HALF, 0, 32'h22,  32'hAAAA_BEEF, 0, 32'h0));
        vecs.push_back(mk(0, SZ_HALF, 1, 32'h22,  32'h0,         0, 32'hFFFF_BEEF));
        vecs.push_back(mk(0, SZ_BYTE, 0, 32'h23,  32'h0,         0, 32'h0000_00BE));
        vecs.push_back(mk(0, SZ_BYTE, 1, 32'h21,  32'h0,         0, 32'hFFFF_FF80));
        vecs.push_back(mk(0, SZ_WORD, 0, 32'h1000, 32'h0,        1, 32'h0));
        vecs.push_back(mk(0, 2'd3,    0, 32'h10,  32'h0,         1, 32'h0));
        vecs.push_back(mk(1, SZ_WORD, 0, 32'h1000, 32'h5555_5555, 1, 32'h0));
        vecs.push_back(mk(1, 2'd3,    0, 32'h10,  32'h6666_6666, 1, 32'h0));
        vecs.push_back(mk(1, SZ_WORD, 0, 32'hFFC, 32'h1234_5678, 0, 32'h0));
        vecs.push_back(mk(0, SZ_WORD, 0, 32'hFFC, 32'h0,         0, 32'h1234_5678));
`ifdef MEM_ACCESS_CTRL_MISALIGN_TRAP_EN
        vecs.push_back(mk(0, SZ_WORD, 0, 32'h13,  32'h0,         1, 32'h0));
        vecs.push_back(mk(0, SZ_HALF, 0, 32'h21,  32'h0,         1, 32'h0));
`else
        vecs.push_back(mk(0, SZ_WORD, 0, 32'h13,  32'h0,         0, 32'hDEAD_A5EF));
        vecs.push_back(mk(0, SZ_HALF, 0, 32'h21,  32'h0,         0, 32'h0000_80F0));
`endif
        vecs.push_back(mk(1, SZ_BYTE, 0, 32'h13,  32'h0000_0011, 0, 32'h0));
        vecs.push_back(mk(0, SZ_WORD, 0, 32'h10,  32'h0,         0, 32'h11AD_A5EF));
`ifdef MEM_ACCESS_CTRL_MISALIGN_TRAP_EN
        vecs.push_back(mk(1, SZ_HALF, 0, 32'h13,  32'h0000_7777, 1, 32'h0));
        vecs.push_back(mk(0, SZ_WORD, 0, 32'h10,  32'h0,         0, 32'h11AD_A5EF));
`else
        vecs.push_back(mk(1, SZ_HALF, 0, 32'h13,  32'h0000_7777, 0, 32'h0));
        vecs.push_back(mk(0, SZ_WORD, 0, 32'h10,  32'h0,         0, 32'h7777_A5EF));
`endif
        vecs.push_back(mk(0, SZ_BYTE, 1, 32'hFFF, 32'h0,         0, 32'h0000_0012));

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_respValid", 32'(respValid), 32'd0);
        check("rst_respErr", 32'(respErr), 32'd0);
        check("rst_respRdata", respRdata, 32'd0);
        check("rst_memRead", 32'(memRead), 32'd0);
        check("rst_memWrite", 32'(memWrite), 32'd0);
        check("rst_memAddress", memAddress, 32'd0);
        check("rst_memWriteData", memWriteData, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Word store then word load at 0x10
        issue(mk(1, SZ_WORD, 0, 32'h10, 32'hDEAD_BEEF, 0, 32'h0), 1'b1, c);
        drain();
        check("st_wr_addr", last_wr_addr, 32'd4);
        check("st_wr_cycle", 32'(last_wr_cyc - c), 32'd1);
        issue(mk(0, SZ_WORD, 0, 32'h10, 32'h0, 0, 32'hDEAD_BEEF), 1'b1, c);
        drain();

        // Vector table, one request at a time
        rd0 = rd_cnt; wr0 = wr_cnt; exp_rd = 0; exp_wr = 0;
        foreach (vecs[i]) begin
            issue(vecs[i], 1'b1, c);
            drain();
            if (!vecs[i].err && (!vecs[i].wr || vecs[i].sz != SZ_WORD)) exp_rd++;
            if (!vecs[i].err && vecs[i].wr) exp_wr++;
        end
        check("table_rd_strobes", 32'(rd_cnt - rd0), 32'(exp_rd));
        check("table_wr_strobes", 32'(wr_cnt - wr0), 32'(exp_wr));
        check("mem_word4_merge", mem[4],
`ifdef MEM_ACCESS_CTRL_MISALIGN_TRAP_EN
              32'h11AD_A5EF);
`else
              32'h7777_A5EF);
`endif

        // Back-to-back loads with reqValid held high
        rd0 = rd_cnt;
        issue(mk(0, SZ_WORD, 0, 32'h20,  32'h0, 0, 32'hBEEF_80F0), 1'b1, c);
        issue(mk(0, SZ_WORD, 0, 32'hFFC, 32'h0, 0, 32'h1234_5678), 1'b1, c);
        issue(mk(0, SZ_BYTE, 0, 32'h20,  32'h0, 0, 32'h0000_00F0), 1'b1, c);
        drain();
        check("b2b_rd_strobes", 32'(rd_cnt - rd0), 32'd3);

        // Reset while the load sits in RD_WAIT: no response may appear
        rc0 = resp_cnt;
        issue(mk(0, SZ_WORD, 0, 32'h10, 32'h0, 0, 32'h0), 1'b0, c);
        @(posedge clk); #1 reqValid = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_ready", 32'(reqReady), 32'd1);
        check("rst_mid_strobes", 32'(memRead | memWrite), 32'd0);
        repeat (6) @(negedge clk);
        check("rst_mid_no_resp", 32'(resp_cnt - rc0), 32'd0);
        issue(mk(0, SZ_BYTE, 1, 32'h22, 32'h0, 0, 32'hFFFF_FFEF), 1'b1, c);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
